// File: rtl/uart_arb_pkg.sv
// Shared state encoding, default sizing and width helpers for the UART arbiters.
// Declarations only: no logic, no latency, no flow control.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SEND = 2'b01,
    S_BUSY = 2'b11,
    S_GAP  = 2'b10
  } arb_state_e;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  localparam int DEF_GAP_CYCLES     = 2;

  // Index/counter width that never collapses to zero bits.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int GRANT_W = grant_w(DEF_NUM_REQ);

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request strictly after rr_ptr_i, wrapping modulo NUM_REQ.
// Purely combinational; valid_o is low when no request is set.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int GW      = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GW-1:0]      rr_ptr_i,
  output logic [GW-1:0]      winner_o,
  output logic               valid_o
);

  function automatic logic [GW-1:0] wrap_idx(input int v);
    return GW'(v % NUM_REQ);
  endfunction

  // Scan from the farthest offset down so the nearest set request wins.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_i[wrap_idx(int'(rr_ptr_i) + k)]) begin
        winner_o = wrap_idx(int'(rr_ptr_i) + k);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter: grant -> tx_send next cycle, ack on busy rise, done on busy fall.
// Losers simply keep req high and wait; a transmitter that never goes busy is abandoned after TIMEOUT_CYCLES.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ        = DEF_NUM_REQ,
  parameter  int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter  int GAP_CYCLES     = DEF_GAP_CYCLES,
  localparam int GW             = grant_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          l_ready_reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          done,
  output logic [GW-1:0]                 grant_id,
  output logic                          active,
  output logic                          timeout_err,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_send,
  input  logic                          tx_busy
);

  localparam int TMO_W = grant_w(TIMEOUT_CYCLES);
  localparam int GAP_W = grant_w(GAP_CYCLES);

  arb_state_e              state_q;
  logic [GW-1:0]           grant_q;
  logic [GW-1:0]           rr_ptr_q;
  logic [DATA_WIDTH-1:0]   tx_data_q;
  logic                    tx_send_q;
  logic [NUM_REQ-1:0]      ack_q;
  logic                    done_q;
  logic                    active_q;
  logic                    err_q;
  logic [TMO_W-1:0]        tmo_cnt_q;
  logic [GAP_W-1:0]        gap_cnt_q;

  logic [TMO_W-1:0]        tmo_cnt_d;
  logic [GAP_W-1:0]        gap_cnt_d;
  logic [NUM_REQ-1:0]      ack_d;
  logic [GW-1:0]           pick_idx;
  logic                    pick_vld;
  logic [DATA_WIDTH-1:0]   pick_dat;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (pick_idx),
    .valid_o  (pick_vld)
  );

  assign pick_dat  = req_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign tmo_cnt_d = tmo_cnt_q + 1'b1;
  assign gap_cnt_d = gap_cnt_q + 1'b1;
  assign ack_d     = NUM_REQ'(1) << grant_q;

  always_ff @(posedge clk or posedge l_ready_reset) begin
    if (l_ready_reset) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= GW'(NUM_REQ - 1);
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
      ack_q     <= '0;
      done_q    <= 1'b0;
      active_q  <= 1'b0;
      err_q     <= 1'b0;
      tmo_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      ack_q  <= '0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            grant_q   <= pick_idx;
            tx_data_q <= pick_dat;
            tx_send_q <= 1'b1;
            active_q  <= 1'b1;
            tmo_cnt_q <= '0;
            state_q   <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_busy) begin
            tx_send_q <= 1'b0;
            ack_q     <= ack_d;
            state_q   <= S_BUSY;
          end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            // Abandon the byte: requester keeps req high and competes again later.
            tx_send_q <= 1'b0;
            err_q     <= 1'b1;
            rr_ptr_q  <= grant_q;
            gap_cnt_q <= '0;
            state_q   <= S_GAP;
          end else begin
            tmo_cnt_q <= tmo_cnt_d;
          end
        end
        S_BUSY: begin
          if (!tx_busy) begin
            done_q    <= 1'b1;
            rr_ptr_q  <= grant_q;
            gap_cnt_q <= '0;
            state_q   <= S_GAP;
          end
        end
        S_GAP: begin
          // Gives the transmitter time to re-enter its send-sampling state.
          if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
            active_q <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack         = ack_q;
  assign done        = done_q;
  assign grant_id    = grant_q;
  assign active      = active_q;
  assign timeout_err = err_q;
  assign tx_data     = tx_data_q;
  assign tx_send     = tx_send_q;

endmodule
